// File: rtl/cache_fill_fsm.sv
`timescale 1ns/1ps
// cache_fill_fsm
//   Miss-handling state machine behind one L1 cache. When a miss is accepted, the
//   FSM fetches the whole aligned block from main memory one word at a time. It
//   streams each returned word into the cache data array, then writes the tag in
//   the cycle the last word lands. While the fill is in progress, fsm_busy stalls
//   the pipeline.
//
// Ports
//   clk, rst_n         clock; synchronous active-low reset
//   miss_detected      lookup missed (sampled in IDLE only)
//   miss_address       byte address that missed (offset bits ignored)
//   fsm_busy           fill in progress
//   memory_en          issue a word read this cycle
//   memory_address     byte address of the word being issued
//   memory_data_valid  memory returns one word this cycle, in issue order
//   memory_data        returned word
//   write_data_array   write fill_data at fill_address
//   fill_address       byte address of the word being written
//   fill_data          combinational copy of memory_data
//   write_tag_array    one-cycle tag/valid write for the block
module cache_fill_fsm #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    output logic              fsm_busy,
    output logic              memory_en,
    output logic [ADDR_W-1:0] memory_address,
    input  logic              memory_data_valid,
    input  logic [DATA_W-1:0] memory_data,
    output logic              write_data_array,
    output logic [ADDR_W-1:0] fill_address,
    output logic [DATA_W-1:0] fill_data,
    output logic              write_tag_array
);

    localparam int CNT_W = $clog2(WORDS) + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(WORDS - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(2 * WORDS - 1);

    typedef enum logic {
        IDLE,
        FILL
    } fillState_t;

    fillState_t        state, nextState;
    logic [ADDR_W-1:0] base, nextBase;
    logic [CNT_W-1:0]  issCnt, nextIssCnt;
    logic [CNT_W-1:0]  rcvCnt, nextRcvCnt;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            base   <= '0;
            issCnt <= '0;
            rcvCnt <= '0;
        end else begin
            state  <= nextState;
            base   <= nextBase;
            issCnt <= nextIssCnt;
            rcvCnt <= nextRcvCnt;
        end
    end

    // Next-state logic. The issue and receive counters advance independently.
    // The fill ends on the final receive, regardless of issue progress.
    always_comb begin
        nextState  = state;
        nextBase   = base;
        nextIssCnt = issCnt;
        nextRcvCnt = rcvCnt;
        unique case (state)
            IDLE: begin
                if (miss_detected) begin
                    nextState  = FILL;
                    nextBase   = miss_address & ~OFF_MASK;
                    nextIssCnt = '0;
                    nextRcvCnt = '0;
                end
            end
            FILL: begin
                if (memory_en) begin
                    nextIssCnt = issCnt + CNT_W'(1);
                end
                if (write_data_array) begin
                    nextRcvCnt = rcvCnt + CNT_W'(1);
                end
                if (write_tag_array) begin
                    nextState = IDLE;
                end
            end
        endcase
    end

    // Output logic. The addresses are held at zero when unused, so no output
    // depends on stale state.
    always_comb begin
        fsm_busy         = 1'b0;
        memory_en        = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        fill_address     = '0;
        write_tag_array  = 1'b0;
        if (state == FILL) begin
            fsm_busy = 1'b1;
            if (issCnt < FULL_CNT) begin
                memory_en      = 1'b1;
                memory_address = base + ADDR_W'({issCnt, 1'b0});
            end
            if (memory_data_valid && (rcvCnt < FULL_CNT)) begin
                write_data_array = 1'b1;
                fill_address     = base + ADDR_W'({rcvCnt, 1'b0});
                write_tag_array  = (rcvCnt == LAST_IDX);
            end
        end
    end

    assign fill_data = memory_data;

endmodule
